// File: rtl/vga_text_pkg.sv
// Shared types and constants for the text-mode renderer: glyph geometry, pipeline depth,
// tile-map word layout and the 16-entry CGA palette (12-bit RGB, red in the top nibble).
package vga_text_pkg;

    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 8;
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] chr;
    } map_word_t;

    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register keeping side-band bits aligned with the pixel pipeline.
// Latency DEPTH cycles; no backpressure, advances every cycle; reset clears every stage.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_pix_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign o_dat = sr[DEPTH-1];

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode pixel pipeline: timing coords -> tile map -> font row -> palette RGB, syncs delayed to match.
// Latency 3 cycles input->RGB/sync; no backpressure. Optional underline cursor under VGA_TEXT_CURSOR_EN.
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter int H_PIX        = 800,
    parameter int V_PIX        = 600,
    parameter int COLS         = H_PIX / GLYPH_W,
    parameter int ROWS         = V_PIX / GLYPH_H,
    parameter int MAP_AW       = 13,
    parameter bit SYNC_ACT_LVL = 1'b1
) (
    input  logic              i_pix_clk,
    input  logic              i_reset,
    input  logic [15:0]       i_horz_coord,
    input  logic [15:0]       i_vert_coord,
    input  logic              i_in_active,
    input  logic              i_horz_sync,
    input  logic              i_vert_sync,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic [6:0]        i_cursor_col,
    input  logic [6:0]        i_cursor_row,
    input  logic              i_cursor_on,
`endif
    output logic [MAP_AW-1:0] o_map_addr,
    input  logic [15:0]       i_map_data,
    output logic [10:0]       o_font_addr,
    input  logic [7:0]        i_font_data,
    output logic [3:0]        o_red,
    output logic [3:0]        o_green,
    output logic [3:0]        o_blue,
    output logic              o_horz_sync,
    output logic              o_vert_sync
);

    logic [31:0] col_w, row_w;
    logic        in_area, act_in;
    map_word_t   map_w;

    assign col_w   = {19'd0, i_horz_coord[15:3]};
    assign row_w   = {19'd0, i_vert_coord[15:3]};
    // Off-screen coords must never light a pixel, even if the generator claims active.
    assign in_area = (col_w < 32'(COLS)) && (row_w < 32'(ROWS));
    assign act_in  = i_in_active && in_area;
    assign map_w   = map_word_t'(i_map_data);

    logic       hs_d2, vs_d2, act_d2;
    logic [2:0] hx_d2, vy_d1;

    vga_delay_line #(.WIDTH(6), .DEPTH(PIPE_LAT - 1)) u_side_dly (
        .i_pix_clk (i_pix_clk),
        .i_reset   (i_reset),
        .i_dat     ({i_horz_sync, i_vert_sync, act_in, i_horz_coord[2:0]}),
        .o_dat     ({hs_d2, vs_d2, act_d2, hx_d2})
    );

    vga_delay_line #(.WIDTH(3), .DEPTH(1)) u_row_dly (
        .i_pix_clk (i_pix_clk),
        .i_reset   (i_reset),
        .i_dat     (i_vert_coord[2:0]),
        .o_dat     (vy_d1)
    );

    logic cur_ul;

`ifdef VGA_TEXT_CURSOR_EN
    logic [7:0] frame_cnt;
    logic       vs_prev, cur_tile_d1, cur_d2;

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            frame_cnt   <= 8'd0;
            vs_prev     <= 1'b0;
            cur_tile_d1 <= 1'b0;
            cur_d2      <= 1'b0;
        end else begin
            vs_prev <= i_vert_sync;
            if (i_vert_sync && !vs_prev) frame_cnt <= frame_cnt + 8'd1;
            cur_tile_d1 <= i_cursor_on && frame_cnt[5] &&
                           (col_w == 32'(i_cursor_col)) && (row_w == 32'(i_cursor_row));
            // Underline occupies the bottom two glyph rows of the cursor tile.
            cur_d2 <= cur_tile_d1 && (vy_d1[2:1] == 2'b11);
        end
    end

    assign cur_ul = cur_d2;
`else
    assign cur_ul = 1'b0;
`endif

    logic [3:0]  fg_d2, bg_d2;
    logic        pix_on;
    logic [11:0] rgb_q;

    assign pix_on = i_font_data[3'd7 - hx_d2] | cur_ul;

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            o_map_addr  <= '0;
            o_font_addr <= '0;
            fg_d2       <= 4'd0;
            bg_d2       <= 4'd0;
            rgb_q       <= 12'h000;
            o_horz_sync <= ~SYNC_ACT_LVL;
            o_vert_sync <= ~SYNC_ACT_LVL;
        end else begin
            o_map_addr  <= MAP_AW'(row_w * 32'(COLS) + col_w);
            o_font_addr <= {map_w.chr, vy_d1};
            fg_d2       <= map_w.fg;
            bg_d2       <= map_w.bg;
            rgb_q       <= act_d2 ? PALETTE[pix_on ? fg_d2 : bg_d2] : 12'h000;
            o_horz_sync <= hs_d2 ? SYNC_ACT_LVL : ~SYNC_ACT_LVL;
            o_vert_sync <= vs_d2 ? SYNC_ACT_LVL : ~SYNC_ACT_LVL;
        end
    end

    assign o_red   = rgb_q[11:8];
    assign o_green = rgb_q[7:4];
    assign o_blue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer: one DUT with active-high syncs, one with active-low syncs,
// both fed from behavioural tile-map and font memories indexed by their registered addresses.
module tb_vga_text_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, act, hs, vs;
    logic [15:0] hc, vc;

    logic [12:0] map_addr, map_addr_n;
    logic [10:0] font_addr, font_addr_n;
    logic [15:0] map_data, map_data_n;
    logic [7:0]  font_data, font_data_n;
    logic [3:0]  r, g, b, r_n, g_n, b_n;
    logic        hso, vso, hso_n, vso_n;
    logic [11:0] rgb_o;

    logic [15:0] map_mem  [8192];
    logic [7:0]  font_mem [2048];

    assign map_data    = map_mem[map_addr];
    assign font_data   = font_mem[font_addr];
    assign map_data_n  = map_mem[map_addr_n];
    assign font_data_n = font_mem[font_addr_n];
    assign rgb_o       = {r, g, b};

    vga_text_renderer #(.SYNC_ACT_LVL(1'b1)) dut (
        .i_pix_clk    (clk),
        .i_reset      (rst),
        .i_horz_coord (hc),
        .i_vert_coord (vc),
        .i_in_active  (act),
        .i_horz_sync  (hs),
        .i_vert_sync  (vs),
`ifdef VGA_TEXT_CURSOR_EN
        .i_cursor_col (7'd0),
        .i_cursor_row (7'd0),
        .i_cursor_on  (1'b0),
`endif
        .o_map_addr   (map_addr),
        .i_map_data   (map_data),
        .o_font_addr  (font_addr),
        .i_font_data  (font_data),
        .o_red        (r),
        .o_green      (g),
        .o_blue       (b),
        .o_horz_sync  (hso),
        .o_vert_sync  (vso)
    );

    vga_text_renderer #(.SYNC_ACT_LVL(1'b0)) dut_n (
        .i_pix_clk    (clk),
        .i_reset      (rst),
        .i_horz_coord (hc),
        .i_vert_coord (vc),
        .i_in_active  (act),
        .i_horz_sync  (hs),
        .i_vert_sync  (vs),
`ifdef VGA_TEXT_CURSOR_EN
        .i_cursor_col (7'd0),
        .i_cursor_row (7'd0),
        .i_cursor_on  (1'b0),
`endif
        .o_map_addr   (map_addr_n),
        .i_map_data   (map_data_n),
        .o_font_addr  (font_addr_n),
        .i_font_data  (font_data_n),
        .o_red        (r_n),
        .o_green      (g_n),
        .o_blue       (b_n),
        .o_horz_sync  (hso_n),
        .o_vert_sync  (vso_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then return at the following falling edge.
    task automatic drive(input logic rs, input int x, input int y,
                         input logic a, input logic h, input logic v);
        rst = rs;
        hc  = 16'(x);
        vc  = 16'(y);
        act = a;
        hs  = h;
        vs  = v;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) map_mem[i] = 16'h0000;
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
        map_mem[0]       = 16'h1F41;
        font_mem[11'h208] = 8'h80;
        map_mem[7499]    = 16'h2C42;
        font_mem[11'h217] = 8'h01;
        map_mem[100]     = 16'hFF41;

        // Reset held mid-line with live syncs and active coords.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3, 5, 1'b1, 1'b1, 1'b1);
            chk("rst_rgb",       32'(rgb_o),     32'h000);
            chk("rst_hsync",     32'(hso),       32'd0);
            chk("rst_vsync",     32'(vso),       32'd0);
            chk("rst_hsync_n",   32'(hso_n),     32'd1);
            chk("rst_map_addr",  32'(map_addr),  32'd0);
            chk("rst_font_addr", 32'(font_addr), 32'd0);
        end

        // Tile (0,0): char 0x41, fg 15, bg 1, glyph row 0 = 0x80.
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, i, 0, (i < 8), 1'b0, 1'b0);
            if (i < 8) chk("t0_map_addr", 32'(map_addr), 32'd0);
            if (i >= 1 && i <= 8) chk("t0_font_addr", 32'(font_addr), 32'h208);
            if (i == 2) chk("t0_rgb_x0", 32'(rgb_o), 32'hFFF);
            if (i >= 3 && i <= 9) chk("t0_rgb_bg", 32'(rgb_o), 32'h00A);
            if (i == 10) chk("t0_rgb_inactive", 32'(rgb_o), 32'h000);
        end

        // Last visible pixel, then off-screen and inactive pixels that would be bright.
        drive(1'b0, 799, 599, 1'b1, 1'b0, 1'b0);
        chk("last_map_addr", 32'(map_addr), 32'd7499);
        drive(1'b0, 800, 0, 1'b1, 1'b0, 1'b0);
        chk("last_font_addr", 32'(font_addr), 32'h217);
        chk("x800_map_addr", 32'(map_addr), 32'd100);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("last_rgb", 32'(rgb_o), 32'hF55);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("x800_rgb_black", 32'(rgb_o), 32'h000);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("inactive_rgb_black", 32'(rgb_o), 32'h000);

        // hsync rises on step 1, vsync falls on step 3; outputs move 3 edges later.
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 840, 0, 1'b0, (k >= 1), (k < 3));
            if (k == 2) begin
                chk("hs_before",   32'(hso),   32'd0);
                chk("hs_n_before", 32'(hso_n), 32'd1);
            end
            if (k == 3) begin
                chk("hs_rise",   32'(hso),   32'd1);
                chk("hs_n_fall", 32'(hso_n), 32'd0);
            end
            if (k == 4) begin
                chk("vs_before",   32'(vso),   32'd1);
                chk("vs_n_before", 32'(vso_n), 32'd0);
            end
            if (k == 5) begin
                chk("vs_fall",   32'(vso),   32'd0);
                chk("vs_n_rise", 32'(vso_n), 32'd1);
            end
        end

        // One-cycle reset with bright pixels in flight: nothing may leak out.
        for (int k = 0; k < 3; k++) drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("flush_rgb_rst",   32'(rgb_o),    32'h000);
        chk("flush_hsync_rst", 32'(hso),      32'd0);
        chk("flush_map_rst",   32'(map_addr), 32'd0);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("flush_rgb_p0", 32'(rgb_o), 32'h000);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("flush_rgb_p1", 32'(rgb_o), 32'h000);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("flush_rgb_p2", 32'(rgb_o), 32'hFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
